sosu: RTL and testbench

SOSU -- requirements
Module: sosu

---
 rtl/sosu_if.sv | 10 +
 rtl/sosu.sv | 82 ++++++++
 tb/tb_sosu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sosu_if.sv
// sosu_if: start/operand request and prime-result handshake for sosu.
interface sosu_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic             y;
  logic             done;
  logic             busy;
  modport master (output start, a, input y, done, busy);
  modport slave (input start, a, output y, done, busy);
endinterface

// File: rtl/sosu.sv
// sosu: sequential primality tester using trial division by repeated subtraction.
module sosu #(parameter int WIDTH = 4) (
  input logic   clk,
  input logic   rst,
  sosu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, DIVIDE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d, r_q, r_d;
  logic yn_q, yn_d, y_q, y_d, done_q, done_d, busy_q, busy_d;
  logic [2*WIDTH-1:0] d1, sq;
  // Next divisor squared, kept double-width so it never wraps.
  assign d1 = {{WIDTH{1'b0}}, d_q} + (2*WIDTH)'(1);
  assign sq = d1 * d1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= WIDTH'(2);
      r_q     <= '0;
      yn_q    <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      yn_q    <= yn_d;
      y_q     <= y_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    yn_d    = yn_q;
    y_d     = y_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (bus.start) begin
        n_d     = bus.a;
        d_d     = WIDTH'(2);
        r_d     = bus.a;
        busy_d  = 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        state_d = (n_q < WIDTH'(2)) || ((n_q >> 2) == '0) ? DONE : DIVIDE;
        yn_d    = !(n_q < WIDTH'(2));
      end
      DIVIDE: begin
        if (r_q == '0) begin
          yn_d    = 1'b0;
          state_d = DONE;
        end else if (r_q >= d_q) begin
          r_d = r_q - d_q;
        end else if (sq > {{WIDTH{1'b0}}, n_q}) begin
          yn_d    = 1'b1;
          state_d = DONE;
        end else begin
          d_d = d_q + WIDTH'(1);
          r_d = n_q;
        end
      end
      default: begin
        y_d     = yn_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  assign bus.y    = y_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_sosu.sv
// tb_sosu: scoreboard bench for sosu at WIDTH=4 and WIDTH=8.
module tb_sosu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic y_hold = 1'b0;
  logic q4[$];
  logic q8[$];
  sosu_if #(.WIDTH(4)) b4 ();
  sosu_if #(.WIDTH(8)) b8 ();
  sosu #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  sosu #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  always #5 clk = ~clk;
  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  always @(negedge clk) if (b4.done) begin
    if (q4.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL done4_unexpected: done=1 with no operand pending at %0t", $time);
    end else chk("y4", b4.y, q4.pop_front());
  end
  always @(negedge clk) if (b8.done) begin
    if (q8.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL done8_unexpected: done=1 with no operand pending at %0t", $time);
    end else chk("y8", b8.y, q8.pop_front());
  end
  task automatic issue(input logic [3:0] v, input logic exp);
    b4.start = 1'b1;
    b4.a = v;
    q4.push_back(exp);
  endtask
  task automatic wait_done(input logic exp, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      b4.start = 1'b0;
      b4.a = 4'($urandom);
      if (!b4.done) begin
        chk("busy_high", b4.busy, 1);
        chk("y_hold", b4.y, y_hold);
      end
    end while (!b4.done && lat < 40);
    chk("done_seen", b4.done, 1);
    if (b4.done) begin
      chk("busy_low_at_done", b4.busy, 0);
      y_hold = exp;
    end
  endtask
  task automatic run8(input logic [7:0] v, input logic exp);
    int n = 0;
    b8.start = 1'b1;
    b8.a = v;
    q8.push_back(exp);
    do begin
      @(negedge clk);
      n++;
      b8.start = 1'b0;
    end while (!b8.done && n < 3000);
    chk("done8_seen", b8.done, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    logic [15:0] primes = 16'h28AC;
    b4.start = 1'b0;
    b4.a = '0;
    b8.start = 1'b0;
    b8.a = '0;
    repeat (2) @(negedge clk);
    chk("rst_y", b4.y, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_busy8", b8.busy, 0);
    rst = 1'b0;
    issue(4'd2, 1'b1);
    wait_done(1'b1, lat);
    chk("lat_a2", lat, 3);
    issue(4'd1, 1'b0);
    wait_done(1'b0, lat);
    chk("lat_a1", lat, 3);
    @(negedge clk);
    chk("busy_idle", b4.busy, 0);
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), primes[i]);
      wait_done(primes[i], lat);
      chk("lat_bound", int'(lat <= 17), 1);
    end
    issue(4'd9, 1'b0);
    wait_done(1'b0, lat);
    issue(4'd11, 1'b1);
    wait_done(1'b1, lat);
    @(negedge clk);
    issue(4'd13, 1'b1);
    @(negedge clk);
    b4.a = 4'd4;
    @(negedge clk);
    b4.start = 1'b0;
    wait_done(1'b1, lat);
    repeat (20) begin
      @(negedge clk);
      chk("no_second_done", b4.done, 0);
    end
    issue(4'd15, 1'b0);
    @(negedge clk);
    b4.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_y", b4.y, 0);
    chk("async_rst_done", b4.done, 0);
    chk("async_rst_busy", b4.busy, 0);
    q4.delete();
    y_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(4'd7, 1'b1);
    wait_done(1'b1, lat);
    chk("lat_a7_after_rst", lat, 7);
    run8(8'd251, 1'b1);
    run8(8'd221, 1'b0);
    run8(8'd255, 1'b0);
    run8(8'd2, 1'b1);
    repeat (5) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
